// File: rtl/battery_manager_mc.sv
// Battery model for the fan controller: saturating charge level, speed-scaled discharge and mode-dependent charging.
// Optional low-level warning output is enabled by defining BAT_LOW_WARN_EN.
module battery_manager_mc #(
   parameter int LEVEL_W      = 8,
   parameter int LEVEL_MAX    = 99,
   parameter int INIT_LEVEL   = 99,
   parameter int SPEED_W      = 2,
   parameter int DISCH_DIV    = 2,
   parameter int CHG_DIV_IDLE = 1,
   parameter int CHG_DIV_RUN  = 2,
   parameter int RESUME_LEVEL = 5,
   parameter int DIV_W        = 4
`ifdef BAT_LOW_WARN_EN
   ,
   parameter int LOW_TH       = 20,
   parameter int LOW_HYST     = 5
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic               charge_en,
   input  logic [SPEED_W-1:0] fan_speed,
   output logic [LEVEL_W-1:0] level,
   output logic               empty,
   output logic               full,
   output logic               charging,
   output logic               fan_allow
`ifdef BAT_LOW_WARN_EN
   ,
   output logic               low_warn
`endif
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DISCH    = 3'd1,
      S_CHG_IDLE = 3'd2,
      S_CHG_RUN  = 3'd3,
      S_EMPTY    = 3'd4
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [DIV_W-1:0]   cnt;
   logic [DIV_W-1:0]   div_m1;
   logic [LEVEL_W-1:0] level_next;
   logic [LEVEL_W-1:0] speed_ext;
   logic               is_chg;
   logic               active;
   logic               step;

   assign is_chg    = (state == S_CHG_IDLE) || (state == S_CHG_RUN);
   assign active    = is_chg || (state == S_DISCH);
   assign speed_ext = LEVEL_W'(fan_speed);

   always_comb begin
      state_next = S_IDLE;
      if (charge_en)
         state_next = (fan_speed != '0) ? S_CHG_RUN : S_CHG_IDLE;
      else if ((level == '0) || (state == S_EMPTY))
         state_next = S_EMPTY;
      else if ((fan_speed != '0) && fan_allow)
         state_next = S_DISCH;
   end

   always_comb begin
      div_m1 = '0;
      case (state)
         S_DISCH:    div_m1 = DIV_W'(DISCH_DIV - 1);
         S_CHG_IDLE: div_m1 = DIV_W'(CHG_DIV_IDLE - 1);
         S_CHG_RUN:  div_m1 = DIV_W'(CHG_DIV_RUN - 1);
         default:    div_m1 = '0;
      endcase
   end

   // A mode change always discards the partial period, even on a tick.
   assign step = tick && active && (state_next == state) && (cnt == div_m1);

   always_comb begin
      level_next = level;
      if (step) begin
         if (state == S_DISCH)
            level_next = (level > speed_ext) ? level - speed_ext : '0;
         else
            level_next = (level < LEVEL_W'(LEVEL_MAX)) ? level + 1'b1 : LEVEL_W'(LEVEL_MAX);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         level     <= LEVEL_W'(INIT_LEVEL);
         fan_allow <= 1'b1;
      end else begin
         state <= state_next;
         level <= level_next;
         if ((state_next != state) || !active)
            cnt <= '0;
         else if (tick)
            cnt <= (cnt == div_m1) ? '0 : cnt + 1'b1;
         // Depletion latches the fan off until the level recovers to the resume point.
         if (!fan_allow && (level_next >= LEVEL_W'(RESUME_LEVEL)))
            fan_allow <= 1'b1;
         else if ((level_next == '0) && !is_chg)
            fan_allow <= 1'b0;
      end
   end

`ifdef BAT_LOW_WARN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         low_warn <= (INIT_LEVEL <= LOW_TH);
      else if (level_next <= LEVEL_W'(LOW_TH))
         low_warn <= 1'b1;
      else if (level_next >= LEVEL_W'(LOW_TH + LOW_HYST))
         low_warn <= 1'b0;
   end
`endif

   assign empty    = (level == '0);
   assign full     = (level == LEVEL_W'(LEVEL_MAX));
   assign charging = is_chg;

endmodule

// File: tb/tb_battery_manager_mc.sv
// Directed testbench for battery_manager_mc with default parameters and hand-computed expectations.
module tb_battery_manager_mc;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic       charge_en;
   logic [1:0] fan_speed;
   logic [7:0] level;
   logic       empty;
   logic       full;
   logic       charging;
   logic       fan_allow;
`ifdef BAT_LOW_WARN_EN
   logic       low_warn;
`endif

   int checks = 0;
   int errors = 0;

   localparam int ST_IDLE     = 0;
   localparam int ST_DISCH    = 1;
   localparam int ST_CHG_IDLE = 2;
   localparam int ST_CHG_RUN  = 3;
   localparam int ST_EMPTY    = 4;

   battery_manager_mc dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .charge_en (charge_en),
      .fan_speed (fan_speed),
      .level     (level),
      .empty     (empty),
      .full      (full),
      .charging  (charging),
      .fan_allow (fan_allow)
`ifdef BAT_LOW_WARN_EN
      ,
      .low_warn  (low_warn)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Each tick is high across exactly one rising edge; outputs are sampled on falling edges.
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      tick      = 1'b0;
      charge_en = 1'b0;
      fan_speed = 2'd0;
      idle(2);
      check("rst_level", int'(level), 99);
      check("rst_empty", int'(empty), 0);
      check("rst_full", int'(full), 1);
      check("rst_charging", int'(charging), 0);
      check("rst_fan_allow", int'(fan_allow), 1);
      check("rst_state", int'(dut.state), ST_IDLE);
`ifdef BAT_LOW_WARN_EN
      check("rst_low_warn", int'(low_warn), 0);
`endif
      rst_n = 1'b1;
      idle(1);

      // Discharge at speed 1: one step per two ticks.
      fan_speed = 2'd1;
      idle(2);
      check("disch_state", int'(dut.state), ST_DISCH);
      ticks(100);
      check("disch100_level", int'(level), 49);
      check("disch100_empty", int'(empty), 0);
      check("disch100_fan_allow", int'(fan_allow), 1);

      // Speed change mid-period keeps the counter; step size sampled at the update.
      ticks(1);
      fan_speed = 2'd2;
      ticks(1);
      check("midperiod_level", int'(level), 47);
      ticks(42);
      check("disch_to5_level", int'(level), 5);

      fan_speed = 2'd3;
      ticks(2);
      check("spd3_level2", int'(level), 2);
      ticks(1);
      check("spd3_half_level", int'(level), 2);
      ticks(1);
      check("spd3_sat_level", int'(level), 0);
      check("spd3_fan_allow", int'(fan_allow), 0);
      check("spd3_empty", int'(empty), 1);
      idle(1);
      check("empty_state", int'(dut.state), ST_EMPTY);
      fan_speed = 2'd1;
      ticks(3);
      check("empty_spd_level", int'(level), 0);
      check("empty_spd_state", int'(dut.state), ST_EMPTY);
`ifdef BAT_LOW_WARN_EN
      check("empty_low_warn", int'(low_warn), 1);
`endif

      // Charge from empty with fan off; fan stays blocked until level 5.
      charge_en = 1'b1;
      fan_speed = 2'd0;
      idle(2);
      check("chg_idle_state", int'(dut.state), ST_CHG_IDLE);
      check("chg_charging", int'(charging), 1);
      ticks(4);
      check("chg4_level", int'(level), 4);
      check("chg4_fan_allow", int'(fan_allow), 0);
      ticks(1);
      check("chg5_level", int'(level), 5);
      check("chg5_fan_allow", int'(fan_allow), 1);
      ticks(5);
      check("chg10_level", int'(level), 10);

      // Charging while fan runs: slower, never discharges.
      fan_speed = 2'd1;
      idle(2);
      check("chg_run_state", int'(dut.state), ST_CHG_RUN);
      ticks(1);
      check("chg_run_half", int'(level), 10);
      ticks(19);
      check("chg_run_level", int'(level), 20);
      check("chg_run_charging", int'(charging), 1);
`ifdef BAT_LOW_WARN_EN
      check("lw20_low_warn", int'(low_warn), 1);
      ticks(8);
      check("lw24_low_warn", int'(low_warn), 1);
      ticks(2);
      check("lw25_low_warn", int'(low_warn), 0);
      ticks(10);
      check("lw30_level", int'(level), 30);
      fan_speed = 2'd0;
      idle(2);
      ticks(67);
`else
      fan_speed = 2'd0;
      idle(2);
      ticks(77);
`endif
      check("chg97_level", int'(level), 97);
      check("chg97_full", int'(full), 0);
      ticks(5);
      check("chg_sat_level", int'(level), 99);
      check("chg_sat_full", int'(full), 1);
      ticks(3);
      check("chg_hold_level", int'(level), 99);

      // Discharge to 50, then charge engages on a tick edge.
      charge_en = 1'b0;
      fan_speed = 2'd1;
      idle(2);
      ticks(98);
      check("disch50_level", int'(level), 50);
      charge_en = 1'b1;
      fan_speed = 2'd0;
      tick      = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      check("coinc_level", int'(level), 50);
      check("coinc_state", int'(dut.state), ST_CHG_IDLE);
      @(negedge clk);
      ticks(1);
      check("coinc_next_level", int'(level), 51);

      // Reset in the middle of a discharge period.
      charge_en = 1'b0;
      fan_speed = 2'd1;
      idle(2);
      ticks(1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_level", int'(level), 99);
      check("midrst_state", int'(dut.state), ST_IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      ticks(1);
      check("postrst_half", int'(level), 99);
      ticks(1);
      check("postrst_step", int'(level), 98);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
